clock_ctrl: RTL and testbench



---
 rtl/clock_ctrl.sv | 150 +++++++++++++++
 tb/tb_clock_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// Timekeeping and time-set controller: 1 Hz divider, HH:MM:SS counters, set-mode FSM.
// Optional field blinking in set modes is enabled by defining CLOCK_BLINK_EN.
module clock_ctrl #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BLINK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [5:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic [2:0] blank,
  output logic       sec_tick
);

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StSetH = 2'd1,
    StSetM = 2'd2,
    StSetS = 2'd3
  } state_e;

  localparam int unsigned DivW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_FREQ - 1);

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [5:0]      hours_q, hours_d;
  logic [5:0]      minutes_q, minutes_d;
  logic [5:0]      seconds_q, seconds_d;
  logic            sec_tick_q;
  logic            tick;

  always_comb begin
    tick      = (state_q == StRun) && (div_q == DivLast);
    div_d     = '0;
    state_d   = state_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;

    // The divider only runs in RUN; SET states park it at zero so RUN restarts a full second.
    if (state_q == StRun && !tick) begin
      div_d = div_q + 1'b1;
    end

    if (tick) begin
      if (seconds_q == 6'd59) begin
        seconds_d = 6'd0;
        if (minutes_q == 6'd59) begin
          minutes_d = 6'd0;
          hours_d   = (hours_q == 6'd23) ? 6'd0 : hours_q + 6'd1;
        end else begin
          minutes_d = minutes_q + 6'd1;
        end
      end else begin
        seconds_d = seconds_q + 6'd1;
      end
    end

    if (btn_mode) begin
      unique case (state_q)
        StRun:   state_d = StSetH;
        StSetH:  state_d = StSetM;
        StSetM:  state_d = StSetS;
        StSetS:  state_d = StRun;
        default: state_d = StRun;
      endcase
    end else if (btn_inc) begin
      unique case (state_q)
        StSetH:  hours_d   = (hours_q == 6'd23) ? 6'd0 : hours_q + 6'd1;
        StSetM:  minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
        StSetS:  seconds_d = (seconds_q == 6'd59) ? 6'd0 : seconds_q + 6'd1;
        default: ;
      endcase
    end
  end

`ifdef CLOCK_BLINK_EN
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_ph_q, blink_ph_d;
  logic [2:0]        blank_q, blank_d;

  always_comb begin
    blink_cnt_d = '0;
    blink_ph_d  = 1'b0;
    // Mode changes and edits restart the blink so the edited field is shown immediately.
    if (!(btn_mode || btn_inc || state_q == StRun)) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_ph_d = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_ph_d  = blink_ph_q;
      end
    end
    blank_d = 3'b000;
    unique case (state_d)
      StSetH:  blank_d = {blink_ph_d, 2'b00};
      StSetM:  blank_d = {1'b0, blink_ph_d, 1'b0};
      StSetS:  blank_d = {2'b00, blink_ph_d};
      default: blank_d = 3'b000;
    endcase
  end

  assign blank = blank_q;
`else
  assign blank = 3'b000;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      div_q       <= '0;
      hours_q     <= 6'd0;
      minutes_q   <= 6'd0;
      seconds_q   <= 6'd0;
      sec_tick_q  <= 1'b0;
`ifdef CLOCK_BLINK_EN
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      blank_q     <= 3'b000;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      hours_q     <= hours_d;
      minutes_q   <= minutes_d;
      seconds_q   <= seconds_d;
      sec_tick_q  <= tick;
`ifdef CLOCK_BLINK_EN
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      blank_q     <= blank_d;
`endif
    end
  end

  assign hours    = hours_q;
  assign minutes  = minutes_q;
  assign seconds  = seconds_q;
  assign mode     = state_q;
  assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: time-of-day reference model compared every cycle,
// directed scenarios with literal expectations, then randomized button traffic.
module tb_clock_ctrl;
  localparam int unsigned CF = 10;
  localparam int unsigned BD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [5:0] hours, minutes, seconds;
  logic [1:0] mode;
  logic [2:0] blank;
  logic       sec_tick;

  clock_ctrl #(.CLK_FREQ(CF), .BLINK_DIV(BD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .hours    (hours),
    .minutes  (minutes),
    .seconds  (seconds),
    .mode     (mode),
    .blank    (blank),
    .sec_tick (sec_tick)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  bit chk_en = 1'b0;

  // Reference model: time of day in seconds, cycles since RUN (re)start, cycles since blink clear.
  int m_tod = 0;
  int m_run = 0;
  int m_mode = 0;
  int m_k = 0;
  int m_tick = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_blank();
    int e;
    e = 0;
`ifdef CLOCK_BLINK_EN
    if (m_mode != 0 && ((m_k / BD) % 2) == 1) e = 1 << (3 - m_mode);
`endif
    return e;
  endfunction

  initial begin
    int h;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_tod = 0; m_run = 0; m_mode = 0; m_k = 0; m_tick = 0;
      end else begin
        m_tick = 0;
        if (m_mode == 0) begin
          m_run = m_run + 1;
          if (m_run % CF == 0) begin
            m_tick = 1;
            m_tod = (m_tod + 1) % 86400;
          end
        end else begin
          m_run = 0;
        end
        if (btn_mode || (btn_inc && m_mode != 0)) m_k = 0;
        else if (m_mode != 0) m_k = m_k + 1;
        if (btn_mode) begin
          m_mode = (m_mode + 1) % 4;
        end else if (btn_inc) begin
          h = m_tod / 3600;
          case (m_mode)
            1: m_tod = ((h + 1) % 24) * 3600 + m_tod % 3600;
            2: m_tod = h * 3600 + (((m_tod / 60) % 60 + 1) % 60) * 60 + m_tod % 60;
            3: m_tod = (m_tod / 60) * 60 + (m_tod % 60 + 1) % 60;
            default: ;
          endcase
        end
        if (m_mode == 0) m_k = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && chk_en) begin
        check("hours", int'(hours), m_tod / 3600);
        check("minutes", int'(minutes), (m_tod / 60) % 60);
        check("seconds", int'(seconds), m_tod % 60);
        check("mode", int'(mode), m_mode);
        check("sec_tick", int'(sec_tick), m_tick);
        check("blank", int'(blank), exp_blank());
      end
    end
  end

  task automatic step(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_time(input int h, input int mi, input int s);
    while (m_mode != 0) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat ((h - m_tod / 3600 + 24) % 24) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    repeat ((mi - (m_tod / 60) % 60 + 60) % 60) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    repeat ((s - m_tod % 60 + 60) % 60) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
  endtask

  task automatic check_hms(input string name, input int h, input int mi, input int s);
    check({name, "_h"}, int'(hours), h);
    check({name, "_m"}, int'(minutes), mi);
    check({name, "_s"}, int'(seconds), s);
  endtask

  initial begin
    @(negedge clk);
    check_hms("reset", 0, 0, 0);
    check("reset_mode", int'(mode), 0);
    check("reset_tick", int'(sec_tick), 0);
    check("reset_blank", int'(blank), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // First tick exactly CF cycles after reset, then a minute of carry.
    idle(9);
    check("pre_tick_s", int'(seconds), 0);
    check("pre_tick", int'(sec_tick), 0);
    idle(1);
    check("first_tick_s", int'(seconds), 1);
    check("first_tick", int'(sec_tick), 1);
    idle(1);
    check("tick_one_cycle", int'(sec_tick), 0);
    idle(589);
    check_hms("one_minute", 0, 1, 0);

    // Midnight rollover on a single edge.
    set_time(23, 59, 59);
    idle(9);
    check_hms("pre_midnight", 23, 59, 59);
    idle(1);
    check_hms("midnight", 0, 0, 0);
    check("midnight_tick", int'(sec_tick), 1);

    // Hours editing wraps mod 24 with no ticks while in SET.
    set_time(5, 17, 42);
    step(1'b1, 1'b0);
    check("set_h_mode", int'(mode), 1);
    repeat (25) step(1'b0, 1'b1);
    check_hms("hours_inc25", 6, 17, 42);
    idle(100);
    check_hms("set_frozen", 6, 17, 42);

    // Minutes wrap without carry; simultaneous mode+inc ignores inc.
    step(1'b1, 1'b0);
    repeat (42) step(1'b0, 1'b1);
    check("min59", int'(minutes), 59);
    step(1'b0, 1'b1);
    check_hms("min_wrap", 6, 0, 42);
    step(1'b1, 1'b1);
    check("both_mode", int'(mode), 3);
    check("both_sec", int'(seconds), 42);

    // Returning to RUN restarts a full second.
    step(1'b1, 1'b0);
    check("back_run", int'(mode), 0);
    idle(9);
    check("run_hold_s", int'(seconds), 42);
    idle(1);
    check("run_tick_s", int'(seconds), 43);

    // Blink pattern in SET_H and clear on edit.
    step(1'b1, 1'b0);
    check("blink_enter", int'(blank), 0);
    for (int i = 1; i <= 9; i++) begin
      idle(1);
`ifdef CLOCK_BLINK_EN
      check("blink_phase", int'(blank), ((i / 4) % 2 == 1) ? 4 : 0);
`else
      check("blink_phase", int'(blank), 0);
`endif
    end
    step(1'b0, 1'b1);
    check("blink_edit", int'(blank), 0);
    check("blink_edit_h", int'(hours), 7);

    // Randomized button traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      btn_mode = ($urandom_range(0, 39) == 0);
      btn_inc  = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    btn_mode = 1'b0;
    btn_inc  = 1'b0;

    // Asynchronous reset mid-cycle while in SET_M.
    set_time(12, 34, 56);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("pre_rst_mode", int'(mode), 2);
    check_hms("pre_rst", 12, 34, 56);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    check_hms("async_rst", 0, 0, 0);
    check("async_rst_mode", int'(mode), 0);
    check("async_rst_blank", int'(blank), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(25);
    check_hms("post_rst", 0, 0, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
